// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared types and constants for the DMA bus-cycle sequencer.
//   dma_state_e : one-hot state vector (SI, S0..S4) with named constants
//   IDX_*       : bit positions of each state inside the one-hot vector
//   dma_mode_e  : channel service mode (demand / single / block / reserved)
//   dma_xfer_e  : transfer direction (verify / write / read / reserved)
//   in_bus_cycle: true while the sequencer owns the bus (S1..S4)
// ---------------------------------------------------------------------------
package dma_pkg;

  localparam int IDX_SI = 0;
  localparam int IDX_S0 = 1;
  localparam int IDX_S1 = 2;
  localparam int IDX_S2 = 3;
  localparam int IDX_S3 = 4;
  localparam int IDX_S4 = 5;

  // One-hot encoding kept as plain constants so older tools and scripts
  // that expect numeric state values can still decode dumps.
  typedef logic [5:0] dma_state_e;
  localparam dma_state_e ST_SI = 6'b000001;
  localparam dma_state_e ST_S0 = 6'b000010;
  localparam dma_state_e ST_S1 = 6'b000100;
  localparam dma_state_e ST_S2 = 6'b001000;
  localparam dma_state_e ST_S3 = 6'b010000;
  localparam dma_state_e ST_S4 = 6'b100000;

  typedef enum logic [1:0] {
    MODE_DEMAND = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_BLOCK  = 2'b10,
    MODE_RSVD   = 2'b11
  } dma_mode_e;

  typedef enum logic [1:0] {
    XFER_VERIFY = 2'b00,
    XFER_WRITE  = 2'b01,
    XFER_READ   = 2'b10,
    XFER_RSVD   = 2'b11
  } dma_xfer_e;

  function automatic logic in_bus_cycle(input dma_state_e s);
    return |s[IDX_S4:IDX_S1];
  endfunction

endpackage

// File: rtl/dma_strobe_decode.sv
// ---------------------------------------------------------------------------
// dma_strobe_decode
// Turns the sequencer state and latched transfer direction into the four
// active-low bus strobes plus the pad output enable.
// Ports:
//   state_i     : one-hot sequencer state
//   xfer_i      : latched transfer direction
//   ext_write_i : extended write, start the write strobe already in S2
//   hlda_i      : hold acknowledge; without it nothing is driven
//   ior_n_o, iow_n_o, memr_n_o, memw_n_o : bus strobes, active low
//   bus_oe_o    : strobe/AEN pad enable
// Macro: DMA_COMPRESSED_TIMING_EN -- S3 does not exist, so the write strobe
//   always starts in S2.
// ---------------------------------------------------------------------------
module dma_strobe_decode
  import dma_pkg::*;
(
  input  dma_state_e state_i,
  input  dma_xfer_e  xfer_i,
  input  logic       ext_write_i,
  input  logic       hlda_i,
  output logic       ior_n_o,
  output logic       iow_n_o,
  output logic       memr_n_o,
  output logic       memw_n_o,
  output logic       bus_oe_o
);

  logic owned;
  logic rd_phase;
  logic wr_phase;
  logic wr_in_s2;
  logic is_read;
  logic is_write;

  // The bus is only ours while HLDA is held and we are past the request
  // phase; losing HLDA releases every strobe in the same cycle.
  assign owned = hlda_i & ~(state_i[IDX_SI] | state_i[IDX_S0]);

`ifdef DMA_COMPRESSED_TIMING_EN
  assign wr_in_s2 = 1'b1 | ext_write_i;
`else
  assign wr_in_s2 = ext_write_i;
`endif

  assign rd_phase = owned & (state_i[IDX_S2] | state_i[IDX_S3] | state_i[IDX_S4]);
  assign wr_phase = owned & ((state_i[IDX_S2] & wr_in_s2) | state_i[IDX_S3] | state_i[IDX_S4]);

  // Verify and the reserved code never drive a strobe.
  assign is_read  = (xfer_i == XFER_READ);
  assign is_write = (xfer_i == XFER_WRITE);

  // Read xfer moves memory to IO: memory is read, IO is written.
  assign memr_n_o = ~(rd_phase & is_read);
  assign iow_n_o  = ~(wr_phase & is_read);
  assign ior_n_o  = ~(rd_phase & is_write);
  assign memw_n_o = ~(wr_phase & is_write);
  assign bus_oe_o = owned;

endmodule

// File: rtl/dma_xfer_timing_fsm.sv
// ---------------------------------------------------------------------------
// dma_xfer_timing_fsm
// DMA bus-cycle sequencer (SI, S0..S4) for NUM_CH channels. Takes the
// arbiter's winning request, runs the HRQ/HLDA handshake and drives AEN,
// ADSTB, DACK and the IO/memory strobes in demand, single or block mode.
// Ports:
//   CLK, RESET        : clock, asynchronous active-high reset
//   req_valid/ch/mode/xfer : arbitrated request, sampled only in SI
//   dreq              : live DREQ lines, used for demand continuation
//   hlda              : hold acknowledge from the CPU
//   eop_in_n          : external end of process, active low
//   tc                : active channel word counter at terminal value
//   addr_lo_wrap      : next address step crosses a 256-byte boundary
//   ext_write         : extended write timing
//   hrq, aen, adstb, dack, ior_n, iow_n, memr_n, memw_n, bus_oe : bus side
//   eop_out_n         : terminal-count EOP, active low
//   addr_step         : advance address / decrement count pulse
//   done, done_ch     : service ended pulse and the channel that ended
// Macro: DMA_COMPRESSED_TIMING_EN -- drop S3 (two clocks per word).
// ---------------------------------------------------------------------------
module dma_xfer_timing_fsm
  import dma_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  input  logic [CH_W-1:0]   req_ch,
  input  logic [1:0]        req_mode,
  input  logic [1:0]        req_xfer,
  input  logic [NUM_CH-1:0] dreq,
  input  logic              hlda,
  input  logic              eop_in_n,
  input  logic              tc,
  input  logic              addr_lo_wrap,
  input  logic              ext_write,
  output logic              hrq,
  output logic              aen,
  output logic              adstb,
  output logic [NUM_CH-1:0] dack,
  output logic              ior_n,
  output logic              iow_n,
  output logic              memr_n,
  output logic              memw_n,
  output logic              bus_oe,
  output logic              eop_out_n,
  output logic              addr_step,
  output logic              done,
  output logic [CH_W-1:0]   done_ch
);

  dma_state_e        state_q, state_d;
  logic [CH_W-1:0]   ch_q;
  dma_mode_e         mode_q;
  dma_xfer_e         xfer_q;
  logic              eop_seen_q;
  logic [CH_W-1:0]   done_ch_q;

  logic [NUM_CH-1:0] ch_oh;
  logic              bus_cycle;
  logic              dreq_ch;
  logic              eop_seen;
  logic              single_mode;
  logic              service_end;
  logic              may_continue;

  assign ch_oh     = NUM_CH'(1) << ch_q;
  assign bus_cycle = in_bus_cycle(state_q);
  assign dreq_ch   = |(dreq & ch_oh);

  // An EOP arriving in the current bus cycle counts immediately so a pulse
  // landing on S4 still ends the service after this word.
  assign eop_seen     = eop_seen_q | (bus_cycle & ~eop_in_n);
  assign single_mode  = (mode_q == MODE_SINGLE) | (mode_q == MODE_RSVD);
  assign service_end  = tc | eop_seen | single_mode;
  assign may_continue = (mode_q == MODE_BLOCK) | ((mode_q == MODE_DEMAND) & dreq_ch);

  // Next-state decision. Any bus state without HLDA falls straight back to
  // SI; S4 either ends, re-enters S1 to restrobe the upper address byte, or
  // skips straight to S2 when the upper byte is unchanged.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SI: if (req_valid) state_d = ST_S0;
      ST_S0: begin
        if (hlda) state_d = ST_S1;
        else if (!dreq_ch && (mode_q != MODE_BLOCK)) state_d = ST_SI;
      end
      ST_S1: state_d = hlda ? ST_S2 : ST_SI;
`ifdef DMA_COMPRESSED_TIMING_EN
      ST_S2: state_d = hlda ? ST_S4 : ST_SI;
`else
      ST_S2: state_d = hlda ? ST_S3 : ST_SI;
`endif
      ST_S3: state_d = hlda ? ST_S4 : ST_SI;
      ST_S4: begin
        if (!hlda || service_end) state_d = ST_SI;
        else if (may_continue) state_d = addr_lo_wrap ? ST_S1 : ST_S2;
        else state_d = ST_SI;
      end
      default: state_d = ST_SI;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_SI;
    else       state_q <= state_d;
  end

  // Service context: channel, mode and direction are captured as the request
  // is accepted and stay put until the next acceptance, so a demand transfer
  // that pauses on DREQ keeps them. The EOP flag lives only for one service,
  // and done_ch keeps the last finished channel for the register file.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ch_q       <= '0;
      mode_q     <= MODE_DEMAND;
      xfer_q     <= XFER_VERIFY;
      eop_seen_q <= 1'b0;
      done_ch_q  <= '0;
    end else begin
      if (state_q[IDX_SI] && req_valid) begin
        ch_q   <= req_ch;
        mode_q <= dma_mode_e'(req_mode);
        xfer_q <= dma_xfer_e'(req_xfer);
      end
      if (state_q[IDX_SI])            eop_seen_q <= 1'b0;
      else if (bus_cycle && !eop_in_n) eop_seen_q <= 1'b1;
      if (done) done_ch_q <= ch_q;
    end
  end

  // Address/handshake outputs straight from the state.
  assign hrq       = ~state_q[IDX_SI];
  assign aen       = bus_cycle;
  assign adstb     = state_q[IDX_S1];
  assign dack      = bus_cycle ? ch_oh : '0;
  assign addr_step = state_q[IDX_S4] & hlda;
  assign done      = addr_step & service_end;
  assign eop_out_n = ~(addr_step & tc);
  assign done_ch   = done ? ch_q : done_ch_q;

  dma_strobe_decode u_strobe (
    .state_i     (state_q),
    .xfer_i      (xfer_q),
    .ext_write_i (ext_write),
    .hlda_i      (hlda),
    .ior_n_o     (ior_n),
    .iow_n_o     (iow_n),
    .memr_n_o    (memr_n),
    .memw_n_o    (memw_n),
    .bus_oe_o    (bus_oe)
  );

endmodule
